// File: rtl/ps2_defs.sv
// Shared scan-code set 2 constants, key indices and decoder state encoding
// for the PS2 key decoder.
package ps2_defs;

    localparam logic [7:0] SC_1     = 8'h16;
    localparam logic [7:0] SC_2     = 8'h1E;
    localparam logic [7:0] SC_3     = 8'h26;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    // Keyboard housekeeping bytes that never start a key sequence
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_BAT_OK = 8'hAA;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_BAT_ER = 8'hFC;
    localparam logic [7:0] SC_ERR_LO = 8'h00;
    localparam logic [7:0] SC_ERR_HI = 8'hFF;

    localparam int NUM_KEYS = 6;

    localparam logic [2:0] K_1     = 3'd0;
    localparam logic [2:0] K_2     = 3'd1;
    localparam logic [2:0] K_3     = 3'd2;
    localparam logic [2:0] K_SPACE = 3'd3;
    localparam logic [2:0] K_ENTER = 3'd4;
    localparam logic [2:0] K_ESC   = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_BREAK     = 2'd1,
        S_EXT       = 2'd2,
        S_EXT_BREAK = 2'd3
    } state_t;

    function automatic logic is_ignored(input logic [7:0] code);
        return (code == SC_ACK)    || (code == SC_BAT_OK) ||
               (code == SC_ECHO)   || (code == SC_BAT_ER) ||
               (code == SC_ERR_LO) || (code == SC_ERR_HI);
    endfunction

endpackage

// File: rtl/ps2_key_map.sv
// Combinational lookup from a scan code to the tracked-key index it controls.
module ps2_key_map
    import ps2_defs::*;
(
    input  logic [7:0] code,
    output logic       hit,
    output logic [2:0] index
);

    always_comb begin
        hit   = 1'b1;
        index = K_1;
        case (code)
            SC_1:     index = K_1;
            SC_2:     index = K_2;
            SC_3:     index = K_3;
            SC_SPACE: index = K_SPACE;
            SC_ENTER: index = K_ENTER;
            SC_ESC:   index = K_ESC;
            default:  hit   = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns a PS2 scan-code set 2 byte stream into held levels, press pulses and
// the last make code, abandoning stale F0/E0 prefixes after a timeout.
module ps2_key_decoder
    import ps2_defs::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic                clk,
    input  logic                iResetn,
    input  logic [7:0]          iData,
    input  logic                iDataEn,
    output logic [NUM_KEYS-1:0] oHeld,
    output logic [NUM_KEYS-1:0] oPress,
    output logic [7:0]          oCode,
    output logic                oCodeValid
);

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;
    logic [NUM_KEYS-1:0] held_next;
    logic                code_fire;
    logic                key_hit;
    logic [2:0]          key_idx;

    ps2_key_map u_key_map (
        .code  (iData),
        .hit   (key_hit),
        .index (key_idx)
    );

    // A byte arriving on the expiry cycle takes priority over the timeout
    always_comb begin
        state_next = state;
        held_next  = oHeld;
        code_fire  = 1'b0;
        if (iDataEn) begin
            case (state)
                S_IDLE: begin
                    if (iData == SC_BREAK) begin
                        state_next = S_BREAK;
                    end else if (iData == SC_EXT) begin
                        state_next = S_EXT;
                    end else if (!is_ignored(iData)) begin
                        code_fire = 1'b1;
                        if (key_hit) begin
                            held_next[key_idx] = 1'b1;
                        end
                    end
                end
                S_BREAK: begin
                    if (key_hit) begin
                        held_next[key_idx] = 1'b0;
                    end
                    state_next = S_IDLE;
                end
                S_EXT: begin
                    state_next = (iData == SC_BREAK) ? S_EXT_BREAK : S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end else if (state != S_IDLE && cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            state      <= S_IDLE;
            cnt        <= '0;
            oHeld      <= '0;
            oPress     <= '0;
            oCode      <= 8'h00;
            oCodeValid <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= (iDataEn || state == S_IDLE) ? '0 : cnt + 1'b1;
            oHeld      <= held_next;
            oPress     <= held_next & ~oHeld;
            oCodeValid <= code_fire;
            if (code_fire) begin
                oCode <= iData;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: stimulus pushes expected code/press
// events, a negedge monitor pops and compares them as the DUT pulses.
module tb_ps2_key_decoder;

    logic       clk = 1'b0;
    logic       iResetn;
    logic [7:0] iData;
    logic       iDataEn;
    logic [5:0] oHeld;
    logic [5:0] oPress;
    logic [7:0] oCode;
    logic       oCodeValid;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] code;
        logic [5:0] held;
    } code_exp_t;

    code_exp_t  code_q[$];
    logic [5:0] press_q[$];

    always #5 clk = ~clk;

    ps2_key_decoder #(
        .TIMEOUT_CYCLES (8),
        .CNT_W          (4)
    ) dut (
        .clk        (clk),
        .iResetn    (iResetn),
        .iData      (iData),
        .iDataEn    (iDataEn),
        .oHeld      (oHeld),
        .oPress     (oPress),
        .oCode      (oCode),
        .oCodeValid (oCodeValid)
    );

    task automatic compare(input string name, input logic [31:0] actual,
                           input logic [31:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
        end
    endtask

    task automatic expect_make(input logic [7:0] code, input logic [5:0] held,
                               input logic [5:0] press);
        code_exp_t e;
        e.code = code;
        e.held = held;
        code_q.push_back(e);
        if (press != 6'b0) press_q.push_back(press);
    endtask

    // Called #1 after a rising edge; leaves the bench #1 after the sampling edge
    task automatic send_byte(input logic [7:0] b);
        iData   = b;
        iDataEn = 1'b1;
        @(posedge clk);
        #1;
        iDataEn = 1'b0;
        iData   = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_held(input string name, input logic [5:0] exp);
        compare(name, {26'b0, oHeld}, {26'b0, exp});
    endtask

    always @(negedge clk) begin
        if (iResetn) begin
            if (oCodeValid) begin
                if (code_q.size() == 0) begin
                    compare("oCodeValid spurious", {31'b0, oCodeValid}, 32'd0);
                end else begin
                    code_exp_t e;
                    e = code_q.pop_front();
                    compare("oCode", {24'b0, oCode}, {24'b0, e.code});
                    compare("oHeld at valid", {26'b0, oHeld}, {26'b0, e.held});
                end
            end
            if (oPress != 6'b0) begin
                if (press_q.size() == 0) begin
                    compare("oPress spurious", {26'b0, oPress}, 32'd0);
                end else begin
                    compare("oPress", {26'b0, oPress}, {26'b0, press_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        iResetn = 1'b0;
        iData   = 8'h00;
        iDataEn = 1'b0;
        idle(3);
        compare("reset oHeld", {26'b0, oHeld}, 32'd0);
        compare("reset oPress", {26'b0, oPress}, 32'd0);
        compare("reset oCode", {24'b0, oCode}, 32'd0);
        compare("reset oCodeValid", {31'b0, oCodeValid}, 32'd0);
        iResetn = 1'b1;
        idle(2);

        // single make then break
        expect_make(8'h16, 6'b000001, 6'b000001);
        send_byte(8'h16);
        send_byte(8'hF0);
        send_byte(8'h16);
        idle(2);
        check_held("make/break 16", 6'b000000);

        // typematic repeats back-to-back
        expect_make(8'h16, 6'b000001, 6'b000001);
        expect_make(8'h16, 6'b000001, 6'b000000);
        expect_make(8'h16, 6'b000001, 6'b000000);
        send_byte(8'h16);
        send_byte(8'h16);
        send_byte(8'h16);
        idle(2);
        check_held("typematic held", 6'b000001);
        send_byte(8'hF0);
        send_byte(8'h16);
        idle(1);
        check_held("typematic release", 6'b000000);

        // two keys held, release one
        expect_make(8'h16, 6'b000001, 6'b000001);
        send_byte(8'h16);
        expect_make(8'h1E, 6'b000011, 6'b000010);
        send_byte(8'h1E);
        idle(1);
        check_held("two keys", 6'b000011);
        send_byte(8'hF0);
        send_byte(8'h16);
        idle(1);
        check_held("release one", 6'b000010);
        send_byte(8'hF0);
        send_byte(8'h1E);
        idle(1);
        check_held("release other", 6'b000000);

        // extended enter is untracked, plain enter is
        send_byte(8'hE0);
        send_byte(8'h5A);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h5A);
        idle(2);
        check_held("extended enter", 6'b000000);
        expect_make(8'h5A, 6'b010000, 6'b010000);
        send_byte(8'h5A);
        idle(1);
        check_held("plain enter", 6'b010000);
        send_byte(8'hF0);
        send_byte(8'h5A);
        idle(1);
        check_held("enter release", 6'b000000);

        // ignore list, untracked make, code persistence
        send_byte(8'hFA);
        send_byte(8'hAA);
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'hEE);
        send_byte(8'hFC);
        expect_make(8'h1C, 6'b000000, 6'b000000);
        send_byte(8'h1C);
        expect_make(8'h29, 6'b001000, 6'b001000);
        send_byte(8'h29);
        send_byte(8'hF0);
        send_byte(8'h29);
        idle(2);
        check_held("space release", 6'b000000);
        compare("oCode persists", {24'b0, oCode}, 32'h29);

        // byte on the expiry cycle is still a break
        expect_make(8'h1E, 6'b000010, 6'b000010);
        send_byte(8'h1E);
        send_byte(8'hF0);
        idle(7);
        send_byte(8'h1E);
        idle(2);
        check_held("break at expiry", 6'b000000);

        // byte one cycle after expiry is a make
        send_byte(8'hF0);
        idle(8);
        expect_make(8'h1E, 6'b000010, 6'b000010);
        send_byte(8'h1E);
        idle(1);
        check_held("make after timeout", 6'b000010);
        send_byte(8'hF0);
        send_byte(8'h1E);
        idle(1);
        check_held("timeout cleanup", 6'b000000);

        // asynchronous reset mid-sequence discards the pending F0
        expect_make(8'h76, 6'b100000, 6'b100000);
        send_byte(8'h76);
        send_byte(8'hF0);
        #2;
        iResetn = 1'b0;
        #1;
        check_held("async reset", 6'b000000);
        compare("async reset oCode", {24'b0, oCode}, 32'd0);
        #1;
        iResetn = 1'b1;
        idle(1);
        expect_make(8'h76, 6'b100000, 6'b100000);
        send_byte(8'h76);
        idle(1);
        check_held("esc after reset", 6'b100000);

        idle(3);
        compare("code queue drained", code_q.size(), 32'd0);
        compare("press queue drained", press_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
